// File: rtl/booth_mac_sequencer.sv
// Controller that drives a sequential Booth multiplier, collects its products and
// accumulates them into saturating signed group sums delimited by in_last.
module booth_mac_sequencer #(
    parameter int WIDTH          = 16,
    parameter int ACC_WIDTH      = 40,
    parameter int RECOVER_CYCLES = 2,
    parameter int TIMEOUT        = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   in_last,
    output logic                   mul_en,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic [2*WIDTH-1:0]     mul_prod,
    input  logic                   mul_done,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   acc_valid,
    output logic                   ovf,
    output logic                   err,
    output logic                   busy
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam int RCNT_W = $clog2(RECOVER_CYCLES + 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RECOVER
    } state_t;

    state_t                 state;
    logic [WCNT_W-1:0]      wait_cnt;
    logic [RCNT_W-1:0]      rec_cnt;
    logic                   last_q;
    logic                   grp_ovf;
    logic [ACC_WIDTH-1:0]   acc;

    logic signed [2*WIDTH-1:0]   prod_s;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0]        sum;
    logic                        add_ovf;
    logic [ACC_WIDTH-1:0]        acc_next;

    // Saturating add of the sign-extended product into the running group sum.
    always_comb begin
        prod_s   = mul_prod;
        prod_ext = ACC_WIDTH'(prod_s);
        sum      = acc + prod_ext;
        add_ovf  = (acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
        acc_next = sum;
        if (add_ovf) begin
            acc_next = acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking writes would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            rec_cnt   <= '0;
            last_q    <= 1'b0;
            grp_ovf   <= 1'b0;
            acc       <= '0;
            mul_en    <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (in_valid && in_ready) begin
                        mul_a    <= in_a;
                        mul_b    <= in_b;
                        last_q   <= in_last;
                        mul_en   <= 1'b1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // done seen on the first WAIT edge may be stale from the previous op
                    if (mul_done && (wait_cnt != '0)) begin
                        mul_en  <= 1'b0;
                        rec_cnt <= '0;
                        state   <= ST_RECOVER;
                        if (last_q) begin
                            acc_out   <= acc_next;
                            acc_valid <= 1'b1;
                            ovf       <= grp_ovf | add_ovf;
                            acc       <= '0;
                            grp_ovf   <= 1'b0;
                        end else begin
                            acc     <= acc_next;
                            grp_ovf <= grp_ovf | add_ovf;
                        end
                    end else if (wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                        err     <= 1'b1;
                        mul_en  <= 1'b0;
                        rec_cnt <= '0;
                        state   <= ST_RECOVER;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end

                ST_RECOVER: begin
                    if (rec_cnt == RCNT_W'(RECOVER_CYCLES - 1)) begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        rec_cnt <= rec_cnt + RCNT_W'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mac_sequencer.sv
// Directed bench: default-width sequencer plus a 34-bit accumulator copy for saturation,
// both fed by one behavioural multiplier that also raises a stale done on its first cycle.
module tb_booth_mac_sequencer;

    localparam int W    = 16;
    localparam int AW   = 40;
    localparam int AW_S = 34;
    localparam int LAT  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic in_valid, in_last;
    logic [W-1:0] in_a, in_b;

    logic in_ready, mul_en, acc_valid, ovf, err, busy;
    logic [W-1:0] mul_a, mul_b;
    logic [AW-1:0] acc_out;

    logic in_ready_s, mul_en_s, acc_valid_s, ovf_s, err_s, busy_s;
    logic [W-1:0] mul_a_s, mul_b_s;
    logic [AW_S-1:0] acc_out_s;

    logic [2*W-1:0] mul_prod;
    logic mul_done;

    booth_mac_sequencer #(.WIDTH(W), .ACC_WIDTH(AW), .RECOVER_CYCLES(2), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
        .mul_prod(mul_prod), .mul_done(mul_done),
        .acc_out(acc_out), .acc_valid(acc_valid), .ovf(ovf), .err(err), .busy(busy)
    );

    booth_mac_sequencer #(.WIDTH(W), .ACC_WIDTH(AW_S), .RECOVER_CYCLES(2), .TIMEOUT(64)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_en(mul_en_s), .mul_a(mul_a_s), .mul_b(mul_b_s),
        .mul_prod(mul_prod), .mul_done(mul_done),
        .acc_out(acc_out_s), .acc_valid(acc_valid_s), .ovf(ovf_s), .err(err_s), .busy(busy_s)
    );

    // Multiplier model: done after LAT cycles of en, garbage done/product on the first cycle.
    logic [7:0] mcnt;
    logic hang;
    logic signed [2*W-1:0] full_prod;

    always @(posedge clk) begin
        if (!mul_en) mcnt <= 8'd0;
        else if (mcnt != 8'hFF) mcnt <= mcnt + 8'd1;
    end

    assign full_prod = 32'(signed'(mul_a)) * 32'(signed'(mul_b));
    assign mul_done  = mul_en && !hang && ((mcnt == 8'd0) || (mcnt >= 8'(LAT)));
    assign mul_prod  = (mcnt == 8'd0) ? 32'h7FFF_FFFF : full_prod;

    int checks = 0;
    int failures = 0;

    int n_valid, n_valid_s, en_cycles, low_cycles, done_cyc, valid_cyc, ctl_diff;
    logic [AW-1:0] got_acc;
    logic [AW_S-1:0] got_acc_s;
    logic got_ovf, got_ovf_s;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic l);
        int n;
        @(negedge clk);
        in_a = a; in_b = b; in_last = l; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 64'(n < 100), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic observe();
        logic done_ok;
        n_valid = 0; n_valid_s = 0; en_cycles = 0; low_cycles = 0;
        done_cyc = -1; valid_cyc = -1; done_ok = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if ((mul_en_s !== mul_en) || (in_ready_s !== in_ready) || (busy_s !== busy) ||
                (err_s !== err) || (mul_a_s !== mul_a) || (mul_b_s !== mul_b)) ctl_diff++;
            if (in_ready) begin
                done_ok = 1'b1;
                break;
            end
            if (mul_en) en_cycles++;
            if (mul_done && mcnt != 8'd0 && done_cyc < 0) done_cyc = i;
            if (acc_valid) begin
                n_valid++; valid_cyc = i; got_acc = acc_out; got_ovf = ovf;
            end
            if (acc_valid_s) begin
                n_valid_s++; got_acc_s = acc_out_s; got_ovf_s = ovf_s;
            end
            if (!mul_en && busy) low_cycles++;
        end
        check("ready_returns", 64'(done_ok), 64'd1);
    endtask

    task automatic pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic l);
        send(a, b, l);
        observe();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
        hang = 1'b0; ctl_diff = 0;
        got_acc = '0; got_acc_s = '0; got_ovf = 1'b0; got_ovf_s = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mul_en", 64'(mul_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_acc_out", 64'(acc_out), 64'd0);
        check("rst_acc_valid", 64'(acc_valid), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(in_ready), 64'd1);

        // Single-pair group with timing checks
        pair(16'h4004, 16'h0002, 1'b1);
        check("single_nvalid", 64'(n_valid), 64'd1);
        check("single_acc", 64'(got_acc), 64'h00_0000_8008);
        check("single_ovf", 64'(got_ovf), 64'd0);
        check("single_en_cycles", 64'(en_cycles), 64'(LAT + 1));
        check("single_valid_delay", 64'(valid_cyc - done_cyc), 64'd1);
        check("single_recover", 64'(low_cycles), 64'd2);
        check("single_acc_s", 64'(got_acc_s), 64'h8008);

        // Two-pair group
        pair(16'h4004, 16'h0002, 1'b0);
        check("two_first_novalid", 64'(n_valid), 64'd0);
        pair(16'h00F0, 16'h0040, 1'b1);
        check("two_nvalid", 64'(n_valid), 64'd1);
        check("two_acc", 64'(got_acc), 64'h00_0000_BC08);

        // Signed groups, fresh accumulator each
        pair(16'hFFFD, 16'h0005, 1'b1);
        check("neg_acc", 64'(got_acc), 64'hFF_FFFF_FFF1);
        check("neg_acc_s", 64'(got_acc_s), 64'h3_FFFF_FFF1);
        pair(16'h0001, 16'h0003, 1'b1);
        check("pos_acc", 64'(got_acc), 64'h00_0000_0003);

        // Saturation on the 34-bit copy; the 40-bit one holds 2^33 exactly
        for (int i = 0; i < 8; i++) pair(16'h8000, 16'h8000, i == 7);
        check("sat_nvalid_s", 64'(n_valid_s), 64'd1);
        check("sat_acc_s", 64'(got_acc_s), 64'h1_FFFF_FFFF);
        check("sat_ovf_s", 64'(got_ovf_s), 64'd1);
        check("wide_acc", 64'(got_acc), 64'h02_0000_0000);
        check("wide_ovf", 64'(got_ovf), 64'd0);
        pair(16'h0004, 16'h0002, 1'b1);
        check("post_sat_acc_s", 64'(got_acc_s), 64'd8);
        check("post_sat_ovf_s", 64'(got_ovf_s), 64'd0);
        check("post_sat_acc", 64'(got_acc), 64'd8);

        // Timeout: multiplier never finishes
        hang = 1'b1;
        pair(16'h0005, 16'h0005, 1'b1);
        check("to_nvalid", 64'(n_valid), 64'd0);
        check("to_en_cycles", 64'(en_cycles), 64'd64);
        check("to_recover", 64'(low_cycles), 64'd2);
        check("to_err", 64'(err), 64'd1);
        hang = 1'b0;
        pair(16'h0002, 16'h0002, 1'b1);
        check("after_to_nvalid", 64'(n_valid), 64'd1);
        check("after_to_acc", 64'(got_acc), 64'd4);
        check("err_sticky", 64'(err), 64'd1);

        // Reset in the middle of WAIT with a partial group pending
        pair(16'h0003, 16'h0003, 1'b0);
        send(16'h0100, 16'h0100, 1'b1);
        repeat (2) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        check("mid_mul_en", 64'(mul_en), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_mul_en", 64'(mul_en), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_err", 64'(err), 64'd0);
        check("mrst_acc_out", 64'(acc_out), 64'd0);
        check("mrst_mul_a", 64'(mul_a), 64'd0);
        @(negedge clk); rst = 1'b0;
        pair(16'h0002, 16'h0003, 1'b1);
        check("post_rst_nvalid", 64'(n_valid), 64'd1);
        check("post_rst_acc", 64'(got_acc), 64'd6);

        check("instances_agree", 64'(ctl_diff), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
